cpx_accumulate: RTL and testbench

Coherent integrate-and-dump stage placed directly downstream of the complex multiplier in the CAF datapath. Sums `length` consecutive complex products (I and Q independently), then presents the sum as one output beat with a valid/ready handshake and restarts from zero. Each output beat is one correlation lag value, ready for the magnitude and peak-search stages.

---
 rtl/cpx_accumulate.sv | 90 +++++++++
 tb/tb_cpx_accumulate.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpx_accumulate.sv
// Coherent integrate-and-dump of complex products: sums `length` I/Q pairs and emits one beat.
// Define CPX_ACCUMULATE_SAT_EN to saturate every addition instead of wrapping.
module cpx_accumulate #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int length   = 64,
    parameter int out_bits = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [i_bits-1:0]   i,
    input  logic [q_bits-1:0]   q,
    input  logic                m_axis_tready,
    output logic                s_axis_tvalid,
    output logic [out_bits-1:0] i_out,
    output logic [out_bits-1:0] q_out
);

    localparam int cnt_bits = $clog2(length);

    logic [cnt_bits-1:0] count_r;
    logic [out_bits-1:0] acc_i_r;
    logic [out_bits-1:0] acc_q_r;
    logic [out_bits-1:0] i_ext_s;
    logic [out_bits-1:0] q_ext_s;
    logic [out_bits-1:0] sum_i_s;
    logic [out_bits-1:0] sum_q_s;
    logic                last_s;
    logic                accept_s;

    // One rail addition; saturating variant clamps to the signed out_bits range.
    function automatic logic [out_bits-1:0] add_rail(input logic [out_bits-1:0] a,
                                                     input logic [out_bits-1:0] b);
`ifdef CPX_ACCUMULATE_SAT_EN
        logic [out_bits:0] wide;
        wide = {a[out_bits-1], a} + {b[out_bits-1], b};
        if (wide[out_bits] != wide[out_bits-1]) begin
            return wide[out_bits] ? {1'b1, {(out_bits-1){1'b0}}} : {1'b0, {(out_bits-1){1'b1}}};
        end else begin
            return wide[out_bits-1:0];
        end
`else
        return a + b;
`endif
    endfunction

    assign i_ext_s  = out_bits'($signed(i));
    assign q_ext_s  = out_bits'($signed(q));
    assign sum_i_s  = add_rail(acc_i_r, i_ext_s);
    assign sum_q_s  = add_rail(acc_q_r, q_ext_s);
    assign last_s   = (count_r == cnt_bits'(length - 1));
    // Only a dump into a still-unaccepted output register must stall the input.
    assign s_axis_tready = !(last_s && s_axis_tvalid && !m_axis_tready);
    assign accept_s = m_axis_tvalid && s_axis_tready;

    // Accumulator, product counter and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r       <= {cnt_bits{1'b0}};
            acc_i_r       <= {out_bits{1'b0}};
            acc_q_r       <= {out_bits{1'b0}};
            i_out         <= {out_bits{1'b0}};
            q_out         <= {out_bits{1'b0}};
            s_axis_tvalid <= 1'b0;
        end else begin
            if (accept_s) begin
                if (last_s) begin
                    count_r <= {cnt_bits{1'b0}};
                    acc_i_r <= {out_bits{1'b0}};
                    acc_q_r <= {out_bits{1'b0}};
                end else begin
                    count_r <= count_r + cnt_bits'(1);
                    acc_i_r <= sum_i_s;
                    acc_q_r <= sum_q_s;
                end
            end
            // A dump on the handoff edge keeps valid high with the fresh sums.
            if (accept_s && last_s) begin
                i_out         <= sum_i_s;
                q_out         <= sum_q_s;
                s_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                s_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpx_accumulate.sv
// Scoreboard bench for cpx_accumulate: reference model of the integrate-and-dump rules plus a
// small 8-bit instance exercising overflow behaviour.
module tb_cpx_accumulate;

    localparam int IB  = 12;
    localparam int QB  = 10;
    localparam int OB  = 12;
    localparam int LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          m_axis_tvalid = 1'b0;
    logic [IB-1:0] i_in = '0;
    logic [QB-1:0] q_in = '0;
    logic          m_axis_tready = 1'b1;
    logic          s_axis_tready;
    logic          s_axis_tvalid;
    logic [OB-1:0] i_out;
    logic [OB-1:0] q_out;

    logic       o_tvalid = 1'b0;
    logic [7:0] o_i = '0;
    logic [7:0] o_q = '0;
    logic       o_sready;
    logic       o_svalid;
    logic [7:0] o_iout;
    logic [7:0] o_qout;

    cpx_accumulate #(.i_bits(IB), .q_bits(QB), .length(LEN), .out_bits(OB)) dut (
        .clk(clk), .rst(rst), .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
        .i(i_in), .q(q_in), .m_axis_tready(m_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .i_out(i_out), .q_out(q_out));

    cpx_accumulate #(.i_bits(8), .q_bits(8), .length(4), .out_bits(8)) dut_ovf (
        .clk(clk), .rst(rst), .m_axis_tvalid(o_tvalid), .s_axis_tready(o_sready),
        .i(o_i), .q(o_q), .m_axis_tready(1'b1), .s_axis_tvalid(o_svalid),
        .i_out(o_iout), .q_out(o_qout));

    typedef struct { int i; int q; } beat_t;
    beat_t exp_q[$];
    beat_t ovf_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    int m_acc_i  = 0;
    int m_acc_q  = 0;
    int m_pend   = 0;
    bit rand_ready = 1'b0;

    // Signed sum folded into an ob-bit signed range: clamp or two's-complement wrap.
    function automatic int fold(input int v, input int ob);
        int lo;
        int hi;
        int m;
        lo = -(1 << (ob - 1));
        hi = (1 << (ob - 1)) - 1;
`ifdef CPX_ACCUMULATE_SAT_EN
        m = (v < lo) ? lo : ((v > hi) ? hi : v);
`else
        m = v & ((1 << ob) - 1);
        if (m > hi) m = m - (1 << ob);
`endif
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the bench's own view of the handshake.
    initial forever begin
        bit acc_ok;
        bit handoff;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_acc_i = 0; m_acc_q = 0; m_pend = 0;
            exp_q.delete();
        end else begin
            acc_ok  = m_axis_tvalid && !(m_cnt == LEN - 1 && m_pend > 0 && !m_axis_tready);
            handoff = (m_pend > 0) && m_axis_tready;
            if (handoff) m_pend--;
            if (acc_ok) begin
                m_acc_i = fold(m_acc_i + int'($signed(i_in)), OB);
                m_acc_q = fold(m_acc_q + int'($signed(q_in)), OB);
                if (m_cnt == LEN - 1) begin
                    exp_q.push_back('{m_acc_i, m_acc_q});
                    m_pend++;
                    m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: checks handshake outputs and pops the scoreboard on each output handoff.
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (!rst) begin
            check("tvalid", int'(s_axis_tvalid), int'(m_pend > 0));
            check("tready", int'(s_axis_tready),
                  int'(!(m_cnt == LEN - 1 && m_pend > 0 && !m_axis_tready)));
            if (s_axis_tvalid && exp_q.size() > 0) begin
                b = exp_q[0];
                check("beat_i", int'($signed(i_out)), b.i);
                check("beat_q", int'($signed(q_out)), b.q);
                if (m_axis_tready) void'(exp_q.pop_front());
            end else if (s_axis_tvalid) begin
                check("unexpected_beat", 1, 0);
            end
            check("ovf_tready", int'(o_sready), 1);
            if (o_svalid) begin
                if (ovf_q.size() > 0) begin
                    b = ovf_q.pop_front();
                    check("ovf_i", int'($signed(o_iout)), b.i);
                    check("ovf_q", int'($signed(o_qout)), b.q);
                end else begin
                    check("ovf_unexpected_beat", 1, 0);
                end
            end
        end
    end

    // Random downstream backpressure while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int iv, input int qv);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        m_axis_tvalid = 1'b1;
        i_in = IB'(iv);
        q_in = QB'(qv);
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) check("send_timeout", 0, 1);
        m_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        m_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_tvalid", int'(s_axis_tvalid), 0);
        check("reset_i_out", int'(i_out), 0);
        check("reset_q_out", int'(q_out), 0);
        check("reset_tready", int'(s_axis_tready), 1);
        @(posedge clk);
        #1;

        // Overflow: 4 x (100,-100) into 8-bit sums.
`ifdef CPX_ACCUMULATE_SAT_EN
        ovf_q.push_back('{127, -128});
`else
        ovf_q.push_back('{-112, 112});
`endif
        o_tvalid = 1'b1;
        o_i = 8'd100;
        o_q = 8'h9C;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        o_tvalid = 1'b0;
        idle(3);

        // Basic dumps, second one proves the restart from zero.
        send(1, -1); send(2, -2); send(3, -3); send(4, -4);
        repeat (4) send(5, 0);
        idle(3);

        // Gapped input.
        send(1, -1); send(2, -2); idle(3); send(3, -3); send(4, -4);
        idle(3);

        // Backpressure: output held, 8th sample stalls until the beat is taken.
        m_axis_tready = 1'b0;
        repeat (7) send(1, 1);
        fork
            send(1, 1);
            begin
                repeat (5) @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        idle(3);

        // Reset mid-accumulation discards the partial sum.
        send(100, 100); send(100, 100);
        pulse_reset();
        repeat (4) send(1, 2);
        idle(3);

        // Randomised products, gaps and backpressure, with one reset in the middle.
        rand_ready = 1'b1;
        for (int k = 0; k < 240; k++) begin
            send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 1023)) - 512);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            if (k == 121) pulse_reset();
        end
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        idle(10);
        check("drained", exp_q.size(), 0);
        check("ovf_drained", ovf_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
